regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, NUM_RD combinational read ports,
// write-to-read bypass and a sequential clear sweep that runs after reset or on request.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     ready
);

  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic              r_ready;
  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic              w_idle;
  logic              w_clr;
  logic              w_wen0, w_wen1;
  logic [ADDR_W-1:0] w_ra;

  assign w_idle = (r_state == ST_IDLE);
  assign w_clr  = rst_n && !w_idle;
  // A write to register 0 with ZERO_REG set is dropped here, so it also never bypasses.
  assign w_wen0 = rst_n && w_idle && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign w_wen1 = rst_n && w_idle && we1 && !((ZERO_REG != 0) && (waddr1 == '0));
  assign ready  = r_ready;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_CLEAR: begin
        w_idx_nxt = r_idx + ADDR_W'(1);
        if (r_idx == '1) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  // NOTE: the storage array has no reset; the clear sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (w_clr) r_mem[r_idx] <= '0;
    if (w_wen0) r_mem[waddr0] <= wdata0;
    if (w_wen1) r_mem[waddr1] <= wdata1;
  end

  // Port 1 is checked first so it wins both the bypass and the stored value on a collision.
  always_comb begin
    rdata = '0;
    w_ra  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_ra = raddr[k*ADDR_W +: ADDR_W];
      if (!w_idle || !re[k]) begin
        rdata[k*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
        rdata[k*DATA_W +: DATA_W] = '0;
      end else if (w_wen1 && (waddr1 == w_ra)) begin
        rdata[k*DATA_W +: DATA_W] = wdata1;
      end else if (w_wen0 && (waddr0 == w_ra)) begin
        rdata[k*DATA_W +: DATA_W] = wdata0;
      end else begin
        rdata[k*DATA_W +: DATA_W] = r_mem[w_ra];
      end
    end
  end

endmodule
